// File: rtl/fetch_byte_pkg.sv
// Shared micro-sequencer constants and the operand-byte halfword-alignment helper
// used by the operand fetch-request generator.
package fetch_byte_pkg;

    // Width of the sequencer state/step counter.
    localparam int ME_SMNL = 4;

    // Byte at index idx sits at an even address when its index parity matches
    // the alignment of the first operand byte.
    function automatic logic byte_at_even_addr(input logic idx_lsb, input logic param_even);
        byte_at_even_addr = ((idx_lsb == 1'b0) == param_even);
    endfunction

endpackage : fetch_byte_pkg

// File: rtl/fetch_byte.sv
// Operand-byte fetch-request generator: pulses fetch once per micro-step whose
// operand byte begins a new 16-bit bytecode halfword.
module fetch_byte
    import fetch_byte_pkg::*;
#(
    parameter int SMNL = ME_SMNL
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [SMNL-1:0] state,
    input  logic            param_even,
    input  logic [7:0]      parameter_number,
    output logic            fetch
);

    localparam int KW = (SMNL > 8) ? SMNL : 8;

    logic [SMNL-1:0] prev_state_r;
    logic            prev_valid_r;

    logic [KW-1:0] k_s;
    logic [KW-1:0] n_s;
    logic [KW-1:0] i_s;
    logic          operand_s;
    logic          even_s;
    logic          req_s;
    logic          new_step_s;

    // Qualify the current step and detect that it has not been serviced yet.
    always_comb begin
        k_s        = {KW{1'b0}};
        n_s        = {KW{1'b0}};
        i_s        = {KW{1'b0}};
        operand_s  = 1'b0;
        even_s     = 1'b0;
        req_s      = 1'b0;
        new_step_s = 1'b0;

        k_s = KW'(state);
        n_s = KW'(parameter_number);
        // Step 0 is the opcode; operand byte i belongs to step i+1.
        i_s = k_s - {{(KW-1){1'b0}}, 1'b1};

        if ((k_s != {KW{1'b0}}) && (k_s <= n_s)) begin
            operand_s = 1'b1;
        end else begin
            operand_s = 1'b0;
        end

        even_s     = byte_at_even_addr(i_s[0], param_even);
        req_s      = operand_s & even_s;
        new_step_s = (~prev_valid_r) | (state != prev_state_r);
    end

    // Output and step-history registers; a held state yields a single pulse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fetch        <= 1'b0;
            prev_state_r <= {SMNL{1'b0}};
            prev_valid_r <= 1'b0;
        end else begin
            fetch        <= req_s & new_step_s;
            prev_state_r <= state;
            prev_valid_r <= 1'b1;
        end
    end

endmodule : fetch_byte

// File: tb/tb_fetch_byte.sv
// Self-checking bench for fetch_byte: directed vector table, multi-cycle corner
// sequences and randomized stimulus against a byte-address reference model.
module tb_fetch_byte;
    import fetch_byte_pkg::*;

    localparam int SMNL   = ME_SMNL;
    localparam int NSTATE = 1 << SMNL;

    logic            clk;
    logic            rst_n;
    logic [SMNL-1:0] state;
    logic            param_even;
    logic [7:0]      parameter_number;
    logic            fetch;

    int errors = 0;
    int checks = 0;

    // Reference model history
    int m_prev_state;
    bit m_prev_valid;

    typedef struct {
        logic            rst_n;
        logic [SMNL-1:0] state;
        logic            pe;
        logic [7:0]      pn;
        logic            exp;
        string           name;
    } vec_t;

    vec_t vecs[$];

    fetch_byte #(.SMNL(SMNL)) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .state            (state),
        .param_even       (param_even),
        .parameter_number (parameter_number),
        .fetch            (fetch)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: fetch=%b expected=%b at t=%0t", name, act, exp, $time);
        end
    endtask

    // Byte address of operand byte i = (first operand address) + i; the first
    // operand address is even when pe=1 and odd otherwise.
    function automatic bit model_req(int k, bit pe, int pn);
        int addr;
        if (k < 1 || k > pn) return 1'b0;
        addr = (pe ? 0 : 1) + (k - 1);
        return (addr % 2) == 0;
    endfunction

    // One clock with rst_n high: predict, advance, compare.
    task automatic model_cycle(input string name);
        bit exp;
        int k;
        k   = int'(state);
        exp = model_req(k, param_even, int'(parameter_number)) &&
              (!m_prev_valid || (k != m_prev_state));
        @(posedge clk);
        #1;
        m_prev_state = k;
        m_prev_valid = 1'b1;
        check(name, fetch, exp);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        #3;
        check("reset_clear", fetch, 1'b0);
        @(posedge clk);
        #1;
        rst_n        = 1'b1;
        m_prev_valid = 1'b0;
        m_prev_state = 0;
    endtask

    function automatic void addv(logic r, int s, logic pe, int pn, logic exp, string name);
        vec_t v;
        v.rst_n = r;
        v.state = SMNL'(s);
        v.pe    = pe;
        v.pn    = 8'(pn);
        v.exp   = exp;
        v.name  = name;
        vecs.push_back(v);
    endfunction

    logic pass_dut[2][NSTATE];

    initial begin
        rst_n            = 1'b0;
        state            = {SMNL{1'b0}};
        param_even       = 1'b0;
        parameter_number = 8'd0;

        // Directed table: each row is applied, one edge taken, fetch compared.
        addv(1'b0, 1, 1'b1, 1, 1'b0, "rst_hold0");
        addv(1'b0, 1, 1'b1, 1, 1'b0, "rst_hold1");
        addv(1'b1, 1, 1'b1, 1, 1'b1, "rst_release");
        addv(1'b1, 1, 1'b1, 1, 1'b0, "rst_release_held");
        addv(1'b1, 0, 1'b1, 3, 1'b0, "even_s0");
        addv(1'b1, 1, 1'b1, 3, 1'b1, "even_s1");
        addv(1'b1, 2, 1'b1, 3, 1'b0, "even_s2");
        addv(1'b1, 3, 1'b1, 3, 1'b1, "even_s3");
        addv(1'b1, 4, 1'b1, 3, 1'b0, "even_s4");
        addv(1'b1, 0, 1'b0, 3, 1'b0, "odd_s0");
        addv(1'b1, 1, 1'b0, 3, 1'b0, "odd_s1");
        addv(1'b1, 2, 1'b0, 3, 1'b1, "odd_s2");
        addv(1'b1, 3, 1'b0, 3, 1'b0, "odd_s3");
        addv(1'b1, 4, 1'b0, 3, 1'b0, "odd_s4");
        addv(1'b1, 1, 1'b1, 0, 1'b0, "pn0_s1");
        addv(1'b1, 2, 1'b0, 0, 1'b0, "pn0_s2");
        addv(1'b1, 3, 1'b1, 5, 1'b1, "hold_s3_first");
        addv(1'b1, 3, 1'b1, 5, 1'b0, "hold_s3_2");
        addv(1'b1, 3, 1'b1, 5, 1'b0, "hold_s3_3");
        addv(1'b1, 3, 1'b1, 5, 1'b0, "hold_s3_4");
        addv(1'b1, 4, 1'b1, 5, 1'b0, "hold_then_s4");
        addv(1'b1, 5, 1'b1, 5, 1'b1, "hold_then_s5");
        addv(1'b1, 5, 1'b0, 7, 1'b0, "held_param_change");
        addv(1'b1, 6, 1'b0, 7, 1'b1, "after_param_change");

        #2;
        foreach (vecs[n]) begin
            rst_n            = vecs[n].rst_n;
            state            = vecs[n].state;
            param_even       = vecs[n].pe;
            parameter_number = vecs[n].pn;
            @(posedge clk);
            #1;
            check(vecs[n].name, fetch, vecs[n].exp);
        end

        // Asynchronous reset during a pulse, then the step is treated as new.
        do_reset();
        state = SMNL'(2); param_even = 1'b1; parameter_number = 8'd4;
        model_cycle("pre_pulse");
        state = SMNL'(3);
        model_cycle("pulse_before_reset");
        check("pulse_is_high", fetch, 1'b1);
        rst_n = 1'b0;
        #1;
        check("async_drop", fetch, 1'b0);
        @(negedge clk);
        check("held_in_reset", fetch, 1'b0);
        rst_n = 1'b1;
        m_prev_valid = 1'b0;
        model_cycle("first_edge_after_reset");
        check("first_edge_pulse", fetch, 1'b1);

        // parameter_number = 0: never a request, across wrap-around.
        parameter_number = 8'd0;
        for (int p = 0; p < 2 * NSTATE; p++) begin
            state      = SMNL'(p % NSTATE);
            param_even = 1'($urandom_range(0, 1));
            model_cycle("pn0_sweep");
            check("pn0_never", fetch, 1'b0);
        end

        // Wrap twice with parameter_number beyond the state range.
        param_even       = 1'b1;
        parameter_number = 8'd255;
        for (int p = 0; p < 2; p++) begin
            for (int s = 0; s < NSTATE; s++) begin
                state = SMNL'(s);
                model_cycle("wrap_sweep");
                pass_dut[p][s] = fetch;
            end
        end
        for (int s = 0; s < NSTATE; s++) begin
            check("wrap_repeat", pass_dut[1][s], pass_dut[0][s]);
        end

        // Randomized stimulus with frequent holds and occasional resets.
        for (int n = 0; n < 400; n++) begin
            if ($urandom_range(0, 99) < 2) begin
                do_reset();
            end
            if ($urandom_range(0, 1) == 0) begin
                state = SMNL'($urandom_range(0, NSTATE - 1));
            end
            if ($urandom_range(0, 3) == 0) param_even = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 3) == 0) begin
                parameter_number = ($urandom_range(0, 3) == 0) ?
                                   8'($urandom_range(0, 255)) : 8'($urandom_range(0, NSTATE));
            end
            model_cycle("random");
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule : tb_fetch_byte
